// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: grants one functional-unit result per cycle
// and broadcasts it on a registered CDB one cycle later.
module cdb_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned SRC_W = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stop,
  input  logic                      flush,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*TAG_W-1:0]    req_tag,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src,
  output logic [31:0]               bcast_cnt
);

  localparam int unsigned SUM_W = SRC_W + 1;
  localparam logic [SUM_W-1:0] NReqSum = SUM_W'(N_REQ);
  localparam logic [SRC_W-1:0] LastIdx = SRC_W'(N_REQ - 1);

  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;
  logic [31:0]       bcast_cnt_q, bcast_cnt_d;

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [SRC_W-1:0]   offset;
  logic [SUM_W-1:0]   idx_sum;
  logic [SRC_W-1:0]   grant_idx;
  logic               arb_en;
  logic               xfer;
  logic [TAG_W-1:0]   tag_sel;
  logic [DATA_W-1:0]  data_sel;

  // Rotate requests so rr_ptr sits at bit 0; the lowest set bit is the winner's distance.
  always_comb begin
    req_dbl = {req_valid, req_valid} >> rr_ptr_q;
    req_rot = req_dbl[N_REQ-1:0];
    offset  = '0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      if (req_rot[k]) offset = SRC_W'(k);
    end
    idx_sum = {1'b0, rr_ptr_q} + {1'b0, offset};
    if (idx_sum >= NReqSum) idx_sum = idx_sum - NReqSum;
    grant_idx = idx_sum[SRC_W-1:0];
    arb_en    = rst & ~stop & ~flush & (|req_valid);
    req_ready = arb_en ? (N_REQ'(1) << grant_idx) : '0;
  end

  always_comb begin
    tag_sel  = '0;
    data_sel = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (req_ready[i]) begin
        tag_sel  = tag_sel  | req_tag[i*TAG_W +: TAG_W];
        data_sel = data_sel | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign xfer = |(req_valid & req_ready);

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    bcast_cnt_d = bcast_cnt_q;
    if (flush) begin
      rr_ptr_d = '0;
    end else if (xfer) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = tag_sel;
      cdb_data_d  = data_sel;
      cdb_src_d   = grant_idx;
      rr_ptr_d    = (grant_idx == LastIdx) ? '0 : grant_idx + SRC_W'(1);
      bcast_cnt_d = bcast_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      bcast_cnt_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
      bcast_cnt_q <= bcast_cnt_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;
  assign bcast_cnt = bcast_cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic against a
// queue-free round-robin reference model; a 3-unit instance checks non-power-of-two wrap.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int TW = 4;
  localparam int DW = 32;

  logic            clk;
  logic            rst_n;
  logic            stop;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic [1:0]      cdb_src;
  logic [31:0]     bcast_cnt;

  logic [2:0]      req3_valid;
  logic [3*TW-1:0] req3_tag;
  logic [3*DW-1:0] req3_data;
  logic [2:0]      req3_ready;
  logic            cdb3_valid;
  logic [TW-1:0]   cdb3_tag;
  logic [DW-1:0]   cdb3_data;
  logic [1:0]      cdb3_src;
  logic [31:0]     bcast3_cnt;

  cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst_n), .stop(stop), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data), .req_ready(req_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src),
    .bcast_cnt(bcast_cnt)
  );

  cdb_arbiter #(.N_REQ(3), .TAG_W(TW), .DATA_W(DW)) dut3 (
    .clk(clk), .rst(rst_n), .stop(stop), .flush(flush),
    .req_valid(req3_valid), .req_tag(req3_tag), .req_data(req3_data), .req_ready(req3_ready),
    .cdb_valid(cdb3_valid), .cdb_tag(cdb3_tag), .cdb_data(cdb3_data), .cdb_src(cdb3_src),
    .bcast_cnt(bcast3_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: what the CDB should show after each edge.
  int          m_ptr;
  logic        m_valid;
  logic [31:0] m_tag;
  logic [31:0] m_data;
  int          m_src;
  logic [31:0] m_cnt;
  int          last_g;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 1'b0; m_tag = '0; m_data = '0; m_src = 0; m_cnt = '0;
  endtask

  // First valid unit scanning upward from the pointer, modulo N; -1 if none may be granted.
  function automatic int model_pick();
    if (!rst_n || stop || flush) return -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    check_eq("cdb_valid", 64'(cdb_valid), 64'(m_valid));
    check_eq("cdb_tag",   64'(cdb_tag),   64'(m_tag[TW-1:0]));
    check_eq("cdb_data",  64'(cdb_data),  64'(m_data));
    check_eq("cdb_src",   64'(cdb_src),   64'(m_src));
    check_eq("bcast_cnt", 64'(bcast_cnt), 64'(m_cnt));
  endtask

  // Entered 1 time unit after a rising edge with inputs already driven.
  task automatic run_cycle();
    int g;
    logic [N-1:0] exp_rdy;
    #1;
    g = model_pick();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
    @(posedge clk);
    if (flush) begin
      m_valid = 1'b0;
      m_ptr   = 0;
    end else if (g >= 0) begin
      m_valid = 1'b1;
      m_tag   = 32'(req_tag[g*TW +: TW]);
      m_data  = req_data[g*DW +: DW];
      m_src   = g;
      m_ptr   = (g + 1) % N;
      m_cnt   = m_cnt + 32'd1;
    end else begin
      m_valid = 1'b0;
    end
    last_g = g;
    #1;
    check_outputs();
  endtask

  task automatic set_unit(input int i, input logic v, input logic [TW-1:0] t,
                          input logic [DW-1:0] d);
    req_valid[i] = v;
    req_tag[i*TW +: TW] = t;
    req_data[i*DW +: DW] = d;
  endtask

  initial begin
    rst_n = 1'b0; stop = 1'b0; flush = 1'b0;
    for (int i = 0; i < N; i++) set_unit(i, 1'b1, TW'(i + 1), 32'h11111111 * (i + 1));
    req3_valid = 3'b111;
    req3_tag   = {4'd3, 4'd2, 4'd1};
    req3_data  = {32'h3333_0000, 32'h2222_0000, 32'h1111_0000};
    model_reset();
    last_g = -1;

    // Reset held with every unit requesting
    #1;
    check_eq("rst_ready", 64'(req_ready), 64'd0);
    check_eq("rst_ready3", 64'(req3_ready), 64'd0);
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // Round robin over all four units; the 3-unit instance must wrap 0,1,2,0,1
    for (int c = 0; c < 5; c++) begin
      run_cycle();
      check_eq("rr_src", 64'(cdb_src), 64'(c % N));
      check_eq("src3", 64'(cdb3_src), 64'(c % 3));
      check_eq("valid3", 64'(cdb3_valid), 64'd1);
    end
    check_eq("rr_cnt5", 64'(bcast_cnt), 64'd5);

    // Sparse: unit 3 alone, then unit 2 alone, then 0 and 3 (pointer must be at 3)
    req_valid = 4'b1000;
    run_cycle();
    set_unit(2, 1'b1, 4'h7, 32'hDEADBEEF);
    req_valid = 4'b0100;
    run_cycle();
    check_eq("sparse_tag", 64'(cdb_tag), 64'h7);
    check_eq("sparse_data", 64'(cdb_data), 64'hDEADBEEF);
    req_valid = 4'b1001;
    run_cycle();
    check_eq("sparse_next", 64'(cdb_src), 64'd3);

    // Stall with units 1 and 3 pending and pointer at 1
    req_valid = 4'b0001;
    run_cycle();
    req_valid = 4'b1010;
    stop = 1'b1;
    for (int c = 0; c < 3; c++) begin
      run_cycle();
      check_eq("stall_valid", 64'(cdb_valid), 64'd0);
    end
    stop = 1'b0;
    run_cycle();
    check_eq("stall_rel1", 64'(cdb_src), 64'd1);
    run_cycle();
    check_eq("stall_rel3", 64'(cdb_src), 64'd3);

    // Flush with pointer at 2 while unit 2 requests; afterwards unit 0 goes first
    req_valid = 4'b0010;
    run_cycle();
    req_valid = 4'b0101;
    flush = 1'b1;
    run_cycle();
    check_eq("flush_valid", 64'(cdb_valid), 64'd0);
    flush = 1'b0;
    run_cycle();
    check_eq("flush_first", 64'(cdb_src), 64'd0);

    // Randomized traffic obeying the requester hold rules, with one mid-run reset
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("midrst_ready", 64'(req_ready), 64'd0);
        check_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
      stop  = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 15) == 0);
      run_cycle();
      for (int i = 0; i < N; i++) begin
        if (flush || last_g == i || !req_valid[i])
          set_unit(i, ($urandom_range(0, 2) != 0), TW'($urandom), $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Round-robin arbiter for the common data bus (CDB) of the dynamic pipeline.
- Up to N_REQ functional-unit result ports (ALU, MUL/DIV, LOAD, ...) request the bus; at most one result is accepted per cycle.
- The accepted result is broadcast one cycle later on a registered CDB to the reservation stations and the register status table.
- Sits between the functional units and pipeline_top's writeback/wakeup logic; obeys the global stall (stop) and the flush.

Parameters:
- N_REQ, 4, number of requesting functional units (2..8).
- TAG_W, 4, reservation-station tag width.
- DATA_W, 32, result data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- stop  in  1  global stall; no acceptance while high.
- flush  in  1  synchronous flush (mispredict/exception).
- req_valid  in  N_REQ  per-unit result valid.
- req_tag  in  N_REQ*TAG_W  per-unit tag; unit i uses bits [i*TAG_W +: TAG_W].
- req_data  in  N_REQ*DATA_W  per-unit result; unit i uses bits [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  one-hot grant (combinational).
- cdb_valid  out  1  broadcast valid (registered, one-cycle pulse per result).
- cdb_tag  out  TAG_W  broadcast tag.
- cdb_data  out  DATA_W  broadcast data.
- cdb_src  out  $clog2(N_REQ)  index of the unit that produced the broadcast.
- bcast_cnt  out  32  total accepted broadcasts, for the res/seg display.

Behaviour:
- Reset (rst=0, async):
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0.
  - rr_ptr=0, bcast_cnt=0.
  - req_ready=0 while reset is asserted.
- Grant (combinational):
  - Scan req_valid starting at rr_ptr, ascending, wrapping mod N_REQ.
  - The first set bit i gets req_ready[i]=1; all other bits are 0.
  - req_ready=0 when stop=1, flush=1, rst=0, or req_valid=0.
  - req_ready never depends on its own value; there is no combinational loop through the requesters.
- Transfer: occurs when req_valid[i] && req_ready[i].
  - Requester rules: hold valid/tag/data stable until the transfer.
  - Requester rules: may raise valid at any time.
  - Requester rules: must not drop valid before the transfer, except on flush.
- Broadcast (registered, latency 1):
  - On the edge after a transfer from unit i: cdb_valid=1, cdb_tag/cdb_data = unit i's inputs, cdb_src=i.
  - On the same edge: rr_ptr=(i+1) mod N_REQ and bcast_cnt+=1 (wraps at 2^32).
- No transfer in a cycle: next-edge cdb_valid=0.
  - cdb_tag/cdb_data/cdb_src hold their last values.
  - rr_ptr and bcast_cnt are unchanged.
- Stall: while stop=1, no transfer occurs and cdb_valid=0 from the next edge, so consumers never capture a result twice.
  - On release, arbitration resumes from the preserved rr_ptr.
- Flush (sync, priority over stop and requests):
  - Next edge: cdb_valid=0, rr_ptr=0.
  - bcast_cnt is preserved.
  - An in-flight broadcast registered on that same edge is discarded.
- Fairness: with K units continuously valid, each is granted once every K cycles. Maximum wait for a valid unit is N_REQ-1 accepting cycles.
- Throughput: back-to-back broadcasts are allowed; cdb_valid may stay high for consecutive cycles with different tags.
- Reset mid-operation: all state is cleared immediately; a pending request is not remembered and is re-arbitrated after reset deasserts.
- Widths: cdb_src width is $clog2(N_REQ). rr_ptr uses the same width, with explicit wrap at N_REQ for non-power-of-two N_REQ.

Test Plan:
- Reset: rst=0 with all req_valid=1.
  - Required: req_ready=0 and cdb_valid=0.
  - Then rst=1: the next edge broadcasts unit 0 (tag 0x1, data 0x11111111), cdb_src=0, bcast_cnt=1.
- Round robin: units 0..3 all valid continuously with tags 1..4.
  - Required: cdb_src sequence 0,1,2,3,0 on consecutive cycles, cdb_valid=1 throughout, bcast_cnt=5 after 5 cycles.
- Sparse requests: only unit 2 valid (tag 0x7, data 0xDEADBEEF) after unit 3 was last granted.
  - Required: granted in the same cycle; the next edge shows cdb_tag=7, cdb_data=0xDEADBEEF, cdb_src=2, and rr_ptr becomes 3.
- Stall: stop=1 for 3 cycles with units 1 and 3 valid and rr_ptr=1.
  - Required: req_ready=0 and cdb_valid=0 for 3 cycles.
  - After release: unit 1 broadcasts first, then unit 3.
- Flush: flush=1 in a cycle where unit 2 is granted and rr_ptr=2.
  - Required: next edge cdb_valid=0 and rr_ptr=0; bcast_cnt is unchanged.
  - Afterwards unit 0 is served first if valid.
- N_REQ=3 build: all units valid.
  - Required: cdb_src sequence 0,1,2,0,1; no grant to a nonexistent index 3.
